encap_tx_scheduler: RTL



---
 rtl/encap_tx_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/encap_tx_scheduler.sv
// Round-robin scheduler and sequencer in front of the encapsulation datapath.
// Grants one requester at a time, latches its payload/address, builds the
// header, pulses start_encap_pkt, waits for encap_done and then acks.
// Optional watchdog: define ENCAP_TX_TIMEOUT_EN to abort stuck packets.
module encap_tx_scheduler #(
  parameter int unsigned NUM_REQ                = 4,
  parameter int unsigned DATA_WIDTH             = 1024,
  parameter int unsigned ADDR_WIDTH             = 10,
  parameter int unsigned RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int unsigned NUMBER_PACKET          = 19,
  parameter int unsigned TTL_WIDTH              = 2,
  parameter int unsigned HEADER_WIDTH           =
      RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH,
  parameter int unsigned LOCAL_ROUTER_ID        = 0,
  parameter int unsigned TTL_INIT               = 2,
  parameter int unsigned TIMEOUT_CYCLES         = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         data_arbiter_send,
  output logic [ADDR_WIDTH-1:0]         router_dst_addr_send,
  output logic [HEADER_WIDTH-1:0]       header_pkt_send,
  output logic                          start_encap_pkt,
  input  logic                          encap_done,
  output logic                          busy,
  output logic [15:0]                   tx_pkt_cnt,
  output logic                          timeout_err
);

  localparam int unsigned SelW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BeatW = $clog2(NUMBER_PACKET);

  // Header is constant for this router: {router id, beats-1, initial TTL}.
  localparam logic [HEADER_WIDTH-1:0] Header = {RECOGNIZE_ROUTER_WIDTH'(LOCAL_ROUTER_ID),
                                                BeatW'(NUMBER_PACKET - 1),
                                                TTL_WIDTH'(TTL_INIT)};

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StAck} state_e;

  state_e                    state_q, state_d;
  logic [SelW-1:0]           ptr_q;
  logic [SelW-1:0]           sel_q;
  logic [SelW-1:0]           grant_idx;
  logic                      grant_valid;
  logic                      grant;
  logic                      done_entry;
  logic                      timeout_hit;
  int unsigned               cand;

  logic [DATA_WIDTH-1:0]     data_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [HEADER_WIDTH-1:0]   header_q;
  logic                      start_q;
  logic                      busy_q;
  logic [NUM_REQ-1:0]        ack_q;
  logic [15:0]               cnt_q;

`ifdef ENCAP_TX_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WdW-1:0] wd_q;
  logic           terr_q;
`endif

  // Round-robin pick: first set request bit at or above ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_valid && req[SelW'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = SelW'(cand);
      end
    end
  end

  // Next-state logic for the packet sequencer.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StStart;
      StStart: state_d = StBusy;  // encap_done deliberately ignored here
      StBusy: begin
        if (encap_done) begin
          state_d = StAck;
`ifdef ENCAP_TX_TIMEOUT_EN
        end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = StAck;
          timeout_hit = 1'b1;
`endif
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign grant      = (state_q == StIdle) && grant_valid;
  assign done_entry = (state_q == StBusy) && (state_d == StAck);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Capture winner's payload, address and header at grant; hold until next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      header_q <= '0;
    end else if (grant) begin
      sel_q    <= grant_idx;
      data_q   <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      addr_q   <= req_dst_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      header_q <= Header;
    end
  end

  // Registered control outputs, completion counter and RR pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      start_q <= (state_d == StStart);
      busy_q  <= (state_d != StIdle);
      ack_q   <= '0;
      if (done_entry) begin
        ack_q[sel_q] <= 1'b1;
        if (!timeout_hit) cnt_q <= cnt_q + 16'd1;
      end
      if (state_q == StAck) begin
        if (sel_q == SelW'(NUM_REQ - 1)) ptr_q <= '0;
        else                             ptr_q <= sel_q + 1'b1;
      end
    end
  end

`ifdef ENCAP_TX_TIMEOUT_EN
  // Watchdog: cleared entering BUSY, counts BUSY cycles; error is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == StStart)     wd_q <= '0;
      else if (state_q == StBusy) wd_q <= wd_q + 1'b1;
      if (timeout_hit) terr_q <= 1'b1;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign ack                  = ack_q;
  assign data_arbiter_send    = data_q;
  assign router_dst_addr_send = addr_q;
  assign header_pkt_send      = header_q;
  assign start_encap_pkt      = start_q;
  assign busy                 = busy_q;
  assign tx_pkt_cnt           = cnt_q;

endmodule
